tlc_time_of_day: RTL and testbench

//  Time-of-day generator that feeds the traffic-light controller top level. It produces BCD hh/mm/ss
//  in 12-hour format, plus pm and peak flags; the controller uses peak to pick its rush-hour timing plan.
//  It sits directly upstream of the controller and divides the system clock down to a one-second tick.

---
 rtl/tlc_pkg.sv | 35 +++
 rtl/tlc_bcd_mod_counter.sv | 46 ++++
 rtl/tlc_time_of_day.sv | 144 ++++++++++++++
 tb/tb_tlc_time_of_day.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared types, BCD limits and default peak-window hours for the traffic-light controller blocks.
package tlc_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [7:0] bcd_byte_t;

  localparam bcd_byte_t BCD_HH_MIN = 8'h01;
  localparam bcd_byte_t BCD_HH_MAX = 8'h12;
  localparam bcd_byte_t BCD_MS_MAX = 8'h59;

  localparam bcd_byte_t PEAK_AM_START_DEF = 8'h08;
  localparam bcd_byte_t PEAK_AM_END_DEF   = 8'h11;
  localparam bcd_byte_t PEAK_PM_START_DEF = 8'h05;
  localparam bcd_byte_t PEAK_PM_END_DEF   = 8'h08;

  // Two-digit BCD increment; the caller handles wrap at its own modulus.
  function automatic bcd_byte_t bcd_inc(input bcd_byte_t v);
    bcd_digit_t lo;
    bcd_digit_t hi;
    lo = v[3:0];
    hi = v[7:4];
    if (lo == 4'd9) begin
      lo = 4'd0;
      hi = hi + 4'd1;
    end else begin
      lo = lo + 4'd1;
    end
    return {hi, lo};
  endfunction

  function automatic logic bcd_in_range(input bcd_byte_t v, input bcd_byte_t lo, input bcd_byte_t hi);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/tlc_bcd_mod_counter.sv
// Two-digit BCD counter with increment, parallel load, wrap at MAX to WRAP, and a carry flag
// that fires on the increment leaving CARRY_AT (defaults to MAX, i.e. the wrap itself).
module tlc_bcd_mod_counter
  import tlc_pkg::*;
#(
  parameter bcd_byte_t MAX      = BCD_MS_MAX,
  parameter bcd_byte_t WRAP     = 8'h00,
  parameter bcd_byte_t RST_VAL  = 8'h00,
  parameter bcd_byte_t CARRY_AT = MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic [7:0] cnt_o,
  output logic [7:0] cnt_nxt_o,
  output logic       carry_o
);

  bcd_byte_t cnt_q, cnt_d;

  // NOTE: every variable written in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = (cnt_q == MAX) ? WRAP : bcd_inc(cnt_q);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;
  assign carry_o   = inc_i && !load_i && (cnt_q == CARRY_AT);

endmodule

// File: rtl/tlc_time_of_day.sv
// Time-of-day generator: BCD 12-hour hh/mm/ss with pm/peak flags and a registered one-second tick.
// Define TOD_TIME_SET_EN to add the validated time-set port group (set_en/set_hh/set_mm/set_ss/set_pm/set_err).
module tlc_time_of_day
  import tlc_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC   = 50_000_000,
  parameter logic [7:0]  PEAK_AM_START = PEAK_AM_START_DEF,
  parameter logic [7:0]  PEAK_AM_END   = PEAK_AM_END_DEF,
  parameter logic [7:0]  PEAK_PM_START = PEAK_PM_START_DEF,
  parameter logic [7:0]  PEAK_PM_END   = PEAK_PM_END_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
`ifdef TOD_TIME_SET_EN
  input  logic       set_en,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  input  logic       set_pm,
  output logic       set_err,
`endif
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       peak,
  output logic       sec_tick
);

  localparam int unsigned PRESC_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_PER_SEC - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               pm_q, pm_d;
  logic               peak_q, peak_d;
  logic               tick_q, tick_d;
  logic               wrap, load, tick;
  bcd_byte_t          load_hh, load_mm, load_ss;
  logic               load_pm;
  bcd_byte_t          hh_q, mm_q, ss_q, hh_nxt, mm_nxt, ss_nxt;
  logic               ss_carry, mm_carry, hh_to_noon;

`ifdef TOD_TIME_SET_EN
  logic set_ok;
  logic set_err_q;

  assign set_ok  = bcd_in_range(set_hh, BCD_HH_MIN, BCD_HH_MAX) &&
                   bcd_in_range(set_mm, 8'h00, BCD_MS_MAX) &&
                   bcd_in_range(set_ss, 8'h00, BCD_MS_MAX);
  assign load    = set_en && set_ok;
  assign load_hh = set_hh;
  assign load_mm = set_mm;
  assign load_ss = set_ss;
  assign load_pm = set_pm;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      set_err_q <= 1'b0;
    end else begin
      set_err_q <= set_en && !set_ok;
    end
  end

  assign set_err = set_err_q;
`else
  assign load    = 1'b0;
  assign load_hh = BCD_HH_MAX;
  assign load_mm = 8'h00;
  assign load_ss = 8'h00;
  assign load_pm = 1'b0;
`endif

  // A valid load beats a coincident prescaler wrap and suppresses its tick.
  assign wrap = ena && (presc_q == PRESC_LAST);
  assign tick = wrap && !load;

  always_comb begin
    presc_d = presc_q;
    if (load) begin
      presc_d = '0;
    end else if (ena) begin
      presc_d = wrap ? '0 : presc_q + 1'b1;
    end
  end

  tlc_bcd_mod_counter #(
    .MAX(BCD_MS_MAX), .WRAP(8'h00), .RST_VAL(8'h00)
  ) u_ss (
    .clk(clk), .rst_n(reset), .inc_i(tick), .load_i(load), .load_val_i(load_ss),
    .cnt_o(ss_q), .cnt_nxt_o(ss_nxt), .carry_o(ss_carry)
  );

  tlc_bcd_mod_counter #(
    .MAX(BCD_MS_MAX), .WRAP(8'h00), .RST_VAL(8'h00)
  ) u_mm (
    .clk(clk), .rst_n(reset), .inc_i(ss_carry), .load_i(load), .load_val_i(load_mm),
    .cnt_o(mm_q), .cnt_nxt_o(mm_nxt), .carry_o(mm_carry)
  );

  // The hour counter's carry is taken at 11 so it marks the 11->12 step that flips AM/PM.
  tlc_bcd_mod_counter #(
    .MAX(BCD_HH_MAX), .WRAP(BCD_HH_MIN), .RST_VAL(BCD_HH_MAX), .CARRY_AT(8'h11)
  ) u_hh (
    .clk(clk), .rst_n(reset), .inc_i(mm_carry), .load_i(load), .load_val_i(load_hh),
    .cnt_o(hh_q), .cnt_nxt_o(hh_nxt), .carry_o(hh_to_noon)
  );

  always_comb begin
    pm_d = pm_q;
    if (load) begin
      pm_d = load_pm;
    end else if (hh_to_noon) begin
      pm_d = !pm_q;
    end
  end

  // Peak is registered from the next-state hour/pm so it moves on the same edge as hh/pm.
  assign peak_d = (!pm_d && (hh_nxt >= PEAK_AM_START) && (hh_nxt < PEAK_AM_END)) ||
                  ( pm_d && (hh_nxt >= PEAK_PM_START) && (hh_nxt < PEAK_PM_END));
  assign tick_d = tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      pm_q    <= 1'b0;
      peak_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      pm_q    <= pm_d;
      peak_q  <= peak_d;
      tick_q  <= tick_d;
    end
  end

  assign hh       = hh_q;
  assign mm       = mm_q;
  assign ss       = ss_q;
  assign pm       = pm_q;
  assign peak     = peak_q;
  assign sec_tick = tick_q;

endmodule

// File: tb/tb_tlc_time_of_day.sv
// Directed bench for tlc_time_of_day at CLK_PER_SEC=4; time-set checks are built when TOD_TIME_SET_EN is defined.
module tb_tlc_time_of_day;

  localparam int unsigned CPS = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       ena;
  logic [7:0] hh, mm, ss;
  logic       pm, peak, sec_tick;
`ifdef TOD_TIME_SET_EN
  logic       set_en = 1'b0;
  logic [7:0] set_hh = 8'h00, set_mm = 8'h00, set_ss = 8'h00;
  logic       set_pm = 1'b0;
  logic       set_err;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] pk_hh, pk_mm, pk_ss;
  logic       pk_pm;

  always #5 clk = ~clk;

  tlc_time_of_day #(.CLK_PER_SEC(CPS)) dut (
    .clk(clk),
    .reset(reset),
    .ena(ena),
`ifdef TOD_TIME_SET_EN
    .set_en(set_en),
    .set_hh(set_hh),
    .set_mm(set_mm),
    .set_ss(set_ss),
    .set_pm(set_pm),
    .set_err(set_err),
`endif
    .hh(hh),
    .mm(mm),
    .ss(ss),
    .pm(pm),
    .peak(peak),
    .sec_tick(sec_tick)
  );

  typedef struct {
    logic [7:0] hh, mm, ss;
    logic       pm, pre_peak;
    logic [7:0] e_hh, e_mm, e_ss;
    logic       e_pm, e_peak;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_time(input string tag, input logic [7:0] e_hh, input logic [7:0] e_mm,
                            input logic [7:0] e_ss, input logic e_pm, input logic e_peak,
                            input logic e_tick);
    check({tag, ".hh"}, hh, e_hh);
    check({tag, ".mm"}, mm, e_mm);
    check({tag, ".ss"}, ss, e_ss);
    check({tag, ".pm"}, pm, e_pm);
    check({tag, ".peak"}, peak, e_peak);
    check({tag, ".sec_tick"}, sec_tick, e_tick);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Preload a time with ena low and the prescaler at zero; peak settles on the edge after release.
  task poke(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic p);
    ena   = 1'b0;
    pk_hh = h;
    pk_mm = m;
    pk_ss = s;
    pk_pm = p;
    force dut.u_hh.cnt_q = pk_hh;
    force dut.u_mm.cnt_q = pk_mm;
    force dut.u_ss.cnt_q = pk_ss;
    force dut.pm_q       = pk_pm;
    force dut.presc_q    = '0;
    cycles(1);
    release dut.u_hh.cnt_q;
    release dut.u_mm.cnt_q;
    release dut.u_ss.cnt_q;
    release dut.pm_q;
    release dut.presc_q;
    cycles(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ticks_seen;

    vecs[0] = '{8'h11, 8'h59, 8'h59, 1'b0, 1'b0, 8'h12, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'h12, 8'h59, 8'h59, 1'b1, 1'b0, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h07, 8'h59, 8'h59, 1'b0, 1'b0, 8'h08, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{8'h10, 8'h59, 8'h59, 1'b0, 1'b1, 8'h11, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h04, 8'h59, 8'h59, 1'b1, 1'b0, 8'h05, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h11, 8'h59, 8'h59, 1'b1, 1'b0, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'h09, 8'h09, 8'h59, 1'b0, 1'b1, 8'h09, 8'h10, 8'h00, 1'b0, 1'b1};
    vecs[7] = '{8'h12, 8'h00, 8'h09, 1'b0, 1'b0, 8'h12, 8'h00, 8'h10, 1'b0, 1'b0};
    vecs[8] = '{8'h07, 8'h59, 8'h59, 1'b1, 1'b1, 8'h08, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[9] = '{8'h12, 8'h59, 8'h59, 1'b0, 1'b0, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0};

    // Reset, release, first tick exactly CPS enabled cycles later.
    reset = 1'b0;
    ena   = 1'b1;
    cycles(2);
    check_time("reset", 8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    cycles(CPS - 1);
    check_time("first_pre", 8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    cycles(1);
    check_time("first_tick", 8'h12, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1);
    cycles(1);
    check("tick_one_cycle", sec_tick, 1'b0);

    // Freeze mid-second for 20 cycles with the prescaler at 2.
    cycles(1);
    ena = 1'b0;
    ticks_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      if (sec_tick) ticks_seen++;
    end
    check("freeze.ticks", ticks_seen, 0);
    check("freeze.ss", ss, 8'h01);
    ena = 1'b1;
    cycles(1);
    check_time("resume_pre", 8'h12, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
    cycles(1);
    check_time("resume_tick", 8'h12, 8'h00, 8'h02, 1'b0, 1'b0, 1'b1);

    // Carry chain, pm and peak transitions from preloaded times.
    foreach (vecs[k]) begin
      poke(vecs[k].hh, vecs[k].mm, vecs[k].ss, vecs[k].pm);
      check($sformatf("vec%0d.pre_peak", k), peak, vecs[k].pre_peak);
      ena = 1'b1;
      cycles(CPS - 1);
      check_time($sformatf("vec%0d.hold", k), vecs[k].hh, vecs[k].mm, vecs[k].ss,
                 vecs[k].pm, vecs[k].pre_peak, 1'b0);
      cycles(1);
      check_time($sformatf("vec%0d.step", k), vecs[k].e_hh, vecs[k].e_mm, vecs[k].e_ss,
                 vecs[k].e_pm, vecs[k].e_peak, 1'b1);
    end

    // Reset mid-second at 05:30:10 PM: immediate return to midnight, partial count discarded.
    poke(8'h05, 8'h30, 8'h10, 1'b1);
    check("midreset.pre_peak", peak, 1'b1);
    ena = 1'b1;
    cycles(2);
    reset = 1'b0;
    #1;
    check_time("midreset.async", 8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("midreset.held_tick", sec_tick, 1'b0);
    reset = 1'b1;
    cycles(CPS - 1);
    check_time("midreset.pre", 8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    cycles(1);
    check_time("midreset.tick", 8'h12, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1);

`ifdef TOD_TIME_SET_EN
    // Invalid hour is ignored and flagged for one cycle.
    poke(8'h03, 8'h00, 8'h00, 1'b0);
    set_en = 1'b1;
    set_hh = 8'h13;
    set_mm = 8'h00;
    set_ss = 8'h00;
    set_pm = 1'b0;
    cycles(1);
    set_en = 1'b0;
    check("set_bad.err", set_err, 1'b1);
    check_time("set_bad.time", 8'h03, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    cycles(1);
    check("set_bad.err_clear", set_err, 1'b0);

    // Valid load coincident with a prescaler wrap: load wins, no tick, prescaler restarts.
    ena = 1'b1;
    cycles(CPS - 1);
    set_en = 1'b1;
    set_hh = 8'h11;
    set_mm = 8'h59;
    set_ss = 8'h59;
    set_pm = 1'b1;
    cycles(1);
    set_en = 1'b0;
    check_time("set_ok.load", 8'h11, 8'h59, 8'h59, 1'b1, 1'b0, 1'b0);
    check("set_ok.err", set_err, 1'b0);
    cycles(CPS - 1);
    check("set_ok.hold_ss", ss, 8'h59);
    cycles(1);
    check_time("set_ok.midnight", 8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
